// File: rtl/regfile_writeback.sv
// Register-file write front end: arbitrates ALU/load results into an in-order FIFO,
// drains one entry per cycle and exports a pending-write bitmap. WB_BYPASS_EN adds a forwarding lookup.
module regfile_writeback #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [ADDR_W-1:0]        ld_rd,
   input  logic [DATA_W-1:0]        ld_data,
   input  logic                     flush,
   output logic                     chip_en,
   output logic                     writeEnable,
   output logic [ADDR_W-1:0]        wRegNum,
   output logic [DATA_W-1:0]        wDataIn,
   output logic [31:0]              pending,
`ifdef WB_BYPASS_EN
   input  logic [ADDR_W-1:0]        fwd_rs0,
   input  logic [ADDR_W-1:0]        fwd_rs1,
   output logic                     fwd_hit0,
   output logic                     fwd_hit1,
   output logic [DATA_W-1:0]        fwd_data0,
   output logic [DATA_W-1:0]        fwd_data1,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] rd_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PW-1:0]     rptr, wptr;
   logic [CW-1:0]     cnt;
   logic              rr_ld;
   logic              can_accept, grant_ld, grant_alu, push, pop;
   logic [ADDR_W-1:0] push_rd;
   logic [DATA_W-1:0] push_data;

   assign count = cnt;
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

   assign can_accept = !full && !flush;
   assign grant_ld   = ld_valid && (!alu_valid || rr_ld);
   assign grant_alu  = alu_valid && !grant_ld;
   assign ld_ready   = can_accept && grant_ld;
   assign alu_ready  = can_accept && grant_alu;
   assign push_rd    = grant_ld ? ld_rd : alu_rd;
   assign push_data  = grant_ld ? ld_data : alu_data;
   // x0 results complete the handshake but never occupy a slot
   assign push       = (ld_ready || alu_ready) && (push_rd != '0);
   assign pop        = !empty && !flush;

   assign writeEnable = !empty;
   assign chip_en     = !empty;
   assign wRegNum     = empty ? '0 : rd_mem[rptr];
   assign wDataIn     = empty ? '0 : data_mem[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr  <= '0;
         wptr  <= '0;
         cnt   <= '0;
         rr_ld <= 1'b1;
      end else begin
         if (can_accept && ld_valid && alu_valid)
            rr_ld <= !rr_ld;
         if (flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
         end else begin
            if (pop)
               rptr <= rptr + 1'b1;
            if (push)
               wptr <= wptr + 1'b1;
            if (push && !pop)
               cnt <= cnt + 1'b1;
            else if (pop && !push)
               cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wptr]   <= push_rd;
         data_mem[wptr] <= push_data;
      end
   end

   logic [PW-1:0] pend_idx;
   always_comb begin
      pending  = '0;
      pend_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_idx = rptr + PW'(i);
         if (CW'(i) < cnt)
            pending[rd_mem[pend_idx]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to youngest so the last match wins
   logic [PW-1:0] fwd_idx;
   always_comb begin
      fwd_hit0  = 1'b0;
      fwd_hit1  = 1'b0;
      fwd_data0 = '0;
      fwd_data1 = '0;
      fwd_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rptr + PW'(i);
         if (CW'(i) < cnt) begin
            if (fwd_rs0 != '0 && rd_mem[fwd_idx] == fwd_rs0) begin
               fwd_hit0  = 1'b1;
               fwd_data0 = data_mem[fwd_idx];
            end
            if (fwd_rs1 != '0 && rd_mem[fwd_idx] == fwd_rs1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_mem[fwd_idx];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based model of the writeback buffer.
module tb_regfile_writeback;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, ld_valid, flush;
   logic        alu_ready, ld_ready;
   logic [4:0]  alu_rd, ld_rd;
   logic [31:0] alu_data, ld_data;
   logic        chip_en, writeEnable;
   logic [4:0]  wRegNum;
   logic [31:0] wDataIn;
   logic [31:0] pending;
   logic [2:0]  count;
   logic        full, empty;
`ifdef WB_BYPASS_EN
   logic [4:0]  fwd_rs0, fwd_rs1;
   logic        fwd_hit0, fwd_hit1;
   logic [31:0] fwd_data0, fwd_data1;
`endif

   always #5 clk = ~clk;

   regfile_writeback #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .flush(flush), .chip_en(chip_en), .writeEnable(writeEnable),
      .wRegNum(wRegNum), .wDataIn(wDataIn), .pending(pending),
`ifdef WB_BYPASS_EN
      .fwd_rs0(fwd_rs0), .fwd_rs1(fwd_rs1), .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
      .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
`endif
      .count(count), .full(full), .empty(empty)
   );

   typedef struct { logic [4:0] rd; logic [31:0] d; } wb_t;
   wb_t mq[$];
   bit  m_rr_ld;
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_pending();
      logic [31:0] p = '0;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic fl,
                       output logic o_ar, output logic o_lr, output logic o_we,
                       output logic [4:0] o_wreg);
      logic can, e_l, e_a;
      @(negedge clk);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
      flush     = fl;
`ifdef WB_BYPASS_EN
      fwd_rs0 = 5'($urandom_range(0, 31));
      fwd_rs1 = (mq.size() != 0 && $urandom_range(0, 1)) ? mq[mq.size()-1].rd : 5'($urandom_range(0, 31));
`endif
      #1;
      can = (mq.size() < DEPTH) && !fl;
      if (lv && av) begin e_l = m_rr_ld; e_a = !m_rr_ld; end
      else begin e_l = lv; e_a = av; end
      check("alu_ready", alu_ready, can && e_a);
      check("ld_ready", ld_ready, can && e_l);
      check("writeEnable", writeEnable, mq.size() != 0);
      check("chip_en", chip_en, mq.size() != 0);
      check("wRegNum", wRegNum, mq.size() != 0 ? mq[0].rd : 5'd0);
      check("wDataIn", wDataIn, mq.size() != 0 ? mq[0].d : 32'd0);
      check("pending", pending, m_pending());
      check("count", count, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
`ifdef WB_BYPASS_EN
      begin
         logic h0 = 0, h1 = 0;
         logic [31:0] d0 = 0, d1 = 0;
         foreach (mq[i]) begin
            if (fwd_rs0 != 0 && mq[i].rd == fwd_rs0) begin h0 = 1; d0 = mq[i].d; end
            if (fwd_rs1 != 0 && mq[i].rd == fwd_rs1) begin h1 = 1; d1 = mq[i].d; end
         end
         check("fwd_hit0", fwd_hit0, h0);
         check("fwd_data0", fwd_data0, d0);
         check("fwd_hit1", fwd_hit1, h1);
         check("fwd_data1", fwd_data1, d1);
      end
`endif
      o_ar = alu_ready; o_lr = ld_ready; o_we = writeEnable; o_wreg = wRegNum;
      @(posedge clk);
      if (can && lv && av) m_rr_ld = !m_rr_ld;
      if (fl) mq.delete();
      else begin
         if (mq.size() != 0) void'(mq.pop_front());
         if (can && e_l && lrd != 0) mq.push_back('{lrd, ldd});
         else if (can && e_a && ard != 0) mq.push_back('{ard, ad});
      end
   endtask

   initial begin
      logic ar, lr, we;
      logic [4:0] wr, a_rd, l_rd;
      logic [4:0] ord [4];
      logic a_v, l_v;
      logic [31:0] a_d, l_d;
      ord = '{5'd1, 5'd11, 5'd2, 5'd12};
      reset = 1'b0; flush = 0; alu_valid = 0; ld_valid = 0;
      alu_rd = 0; ld_rd = 0; alu_data = 0; ld_data = 0;
`ifdef WB_BYPASS_EN
      fwd_rs0 = 0; fwd_rs1 = 0;
`endif
      m_rr_ld = 1;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;

      // idle after reset
      step(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wr);
      check("reset_we", we, 0);

      // tie: load wins first, then alternate
      l_rd = 1; a_rd = 11;
      for (int i = 0; i < 4; i++) begin
         step(1, a_rd, 32'h200 + a_rd, 1, l_rd, 32'h100 + l_rd, 0, ar, lr, we, wr);
         check("tie_ld_grant", lr, (i % 2) == 0);
         check("tie_alu_grant", ar, (i % 2) == 1);
         if (i > 0) check("drain_order", wr, ord[i-1]);
         if (lr) l_rd++;
         if (ar) a_rd++;
      end
      step(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wr);
      check("drain_order", wr, ord[3]);

      // single write latency
      step(1, 5, 32'h12345678, 0, 0, 0, 0, ar, lr, we, wr);
      check("single_ready", ar, 1);
      step(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wr);
      check("single_we", we, 1);
      check("single_rd", wr, 5);
      check("single_wdata", wDataIn, 32'h12345678);
      check("single_pend5", pending[5], 1);
      step(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wr);
      check("single_done", we, 0);

      // x0 write
      step(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, ar, lr, we, wr);
      check("x0_ready", ar, 1);
      step(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wr);
      check("x0_no_we", we, 0);
      check("x0_count", count, 0);

      // flush with an entry buffered and a result offered
      step(1, 9, 32'h9, 0, 0, 0, 0, ar, lr, we, wr);
      step(1, 10, 32'hA, 1, 3, 32'h3, 1, ar, lr, we, wr);
      check("flush_ready", ar | lr, 0);
      check("flush_we_head", we, 1);
      step(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wr);
      check("flush_we", we, 0);
      check("flush_pending", pending, 0);

      // randomized traffic with sources holding until accepted
      a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!a_v && $urandom_range(0, 2) == 0) begin
            a_v = 1; a_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); a_d = $urandom;
         end
         if (!l_v && $urandom_range(0, 2) == 0) begin
            l_v = 1; l_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); l_d = $urandom;
         end
         step(a_v, a_rd, a_d, l_v, l_rd, l_d, $urandom_range(0, 15) == 0, ar, lr, we, wr);
         if (ar) a_v = 0;
         if (lr) l_v = 0;
         if (n == 1500) begin
            @(negedge clk);
            alu_valid = 0; ld_valid = 0; flush = 0;
            #1 ld_valid = 1; ld_rd = 5'd17; ld_data = 32'h17;
            #1 reset = 1'b0;
            #1;
            check("async_rst_count", count, 0);
            check("async_rst_we", writeEnable, 0);
            check("async_rst_pending", pending, 0);
            check("async_rst_wreg", wRegNum, 0);
            @(posedge clk);
            @(negedge clk); reset = 1'b1; ld_valid = 0;
            mq.delete(); m_rr_ld = 1; a_v = 0; l_v = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
